// File: rtl/bpsk_pkg.sv
// Shared constants for the BPSK modulator: carrier table, symbol lengths,
// rate codes and FSM states.
package bpsk_pkg;

    localparam int         CARRIER_LEN = 16;
    localparam int         IDX_W       = $clog2(CARRIER_LEN);

    localparam logic [8:0] SYM_LEN_10K = 9'd200;
    localparam logic [8:0] SYM_LEN_8K  = 9'd250;
    localparam logic [8:0] SYM_LEN_6K  = 9'd333;

    localparam logic [7:0] FREQ_10K    = 8'd10;
    localparam logic [7:0] FREQ_8K     = 8'd8;
    localparam logic [7:0] FREQ_6K     = 8'd6;

    localparam logic [9:0] DAC_ZERO    = 10'd512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // One full sine period in offset binary, 16 samples per 2 MHz cycle.
    function automatic logic [9:0] sine_lut(input logic [IDX_W-1:0] i);
        logic [9:0] v;
        case (i)
            4'd0:    v = 10'd512;
            4'd1:    v = 10'd708;
            4'd2:    v = 10'd873;
            4'd3:    v = 10'd984;
            4'd4:    v = 10'd1023;
            4'd5:    v = 10'd984;
            4'd6:    v = 10'd873;
            4'd7:    v = 10'd708;
            4'd8:    v = 10'd512;
            4'd9:    v = 10'd316;
            4'd10:   v = 10'd151;
            4'd11:   v = 10'd40;
            4'd12:   v = 10'd1;
            4'd13:   v = 10'd40;
            4'd14:   v = 10'd151;
            4'd15:   v = 10'd316;
            default: v = DAC_ZERO;
        endcase
        return v;
    endfunction

    // Symbol length in carrier periods; unknown codes fall back to 10 kbit/s.
    function automatic logic [8:0] sym_len_of(input logic [7:0] f);
        logic [8:0] v;
        case (f)
            FREQ_10K: v = SYM_LEN_10K;
            FREQ_8K:  v = SYM_LEN_8K;
            FREQ_6K:  v = SYM_LEN_6K;
            default:  v = SYM_LEN_10K;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7+x^6+1) bit source, seed 7'h7F; one new bit per i_adv.
module prbs7_gen (
    input  logic clk_32m,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_adv,
    output logic o_bit
);

    logic [6:0] r_lfsr;

    // LFSR: reseed on clear, shift once per consumed bit.
    always_ff @(posedge clk_32m or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 7'h7F;
        end else if (i_clr) begin
            r_lfsr <= 7'h7F;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign o_bit = r_lfsr[6];

endmodule

// File: rtl/bpsk_mod.sv
// BPSK modulator: 2 MHz carrier from a 16-entry sine table at 32 MHz, 180 deg per bit.
// Optional BPSK_PRBS_GEN_EN replaces bit_in with an internal PRBS7 source.
module bpsk_mod
    import bpsk_pkg::*;
(
    input  logic       clk_32m,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] freq,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic [9:0] dac_data
);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [8:0]       r_pcnt;
    logic [8:0]       r_sym_len;
    logic             r_bit;
    logic             r_bit_ready;
    logic [9:0]       r_dac;
    logic             w_bit_src;
    logic             w_phase;

`ifdef BPSK_PRBS_GEN_EN
    logic w_prbs_bit;

    prbs7_gen u_prbs7_gen (
        .clk_32m (clk_32m),
        .rst_n   (rst_n),
        .i_clr   (r_state == IDLE),
        .i_adv   (r_bit_ready),
        .o_bit   (w_prbs_bit)
    );

    assign w_bit_src = w_prbs_bit;
`else
    assign w_bit_src = bit_in;
`endif

    // mode acts immediately; the data bit only changes on a strobe.
    assign w_phase = r_bit & mode;

    // Sequencer: idle / one-cycle load / run with symbol-boundary strobe.
    always_ff @(posedge clk_32m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 4'd0;
            r_pcnt      <= 9'd0;
            r_sym_len   <= SYM_LEN_10K;
            r_bit       <= 1'b0;
            r_bit_ready <= 1'b0;
        end else if (!en) begin
            r_state     <= IDLE;
            r_idx       <= 4'd0;
            r_pcnt      <= 9'd0;
            r_bit       <= 1'b0;
            r_bit_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state     <= LOAD;
                    r_idx       <= 4'd0;
                    r_pcnt      <= 9'd0;
                    r_bit_ready <= 1'b1;
                end
                LOAD: begin
                    r_state     <= RUN;
                    r_idx       <= 4'd0;
                    r_pcnt      <= 9'd0;
                    r_bit       <= w_bit_src;
                    r_sym_len   <= sym_len_of(freq);
                    r_bit_ready <= 1'b0;
                end
                RUN: begin
                    r_idx <= r_idx + 4'd1;
                    if (r_bit_ready) begin
                        // Strobe cycle is idx 15 of the last period: take the next symbol.
                        r_bit       <= w_bit_src;
                        r_sym_len   <= sym_len_of(freq);
                        r_pcnt      <= 9'd0;
                        r_bit_ready <= 1'b0;
                    end else begin
                        r_bit_ready <= (r_idx == 4'd14) && (r_pcnt == r_sym_len - 9'd1);
                        if (r_idx == 4'd15) begin
                            r_pcnt <= r_pcnt + 9'd1;
                        end else begin
                            r_pcnt <= r_pcnt;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_bit_ready <= 1'b0;
                end
            endcase
        end
    end

    // Registered DAC sample; XOR on idx bit 3 is the half-period phase flip.
    always_ff @(posedge clk_32m or negedge rst_n) begin
        if (!rst_n) begin
            r_dac <= DAC_ZERO;
        end else if (r_state == RUN) begin
            r_dac <= sine_lut(r_idx ^ {w_phase, 3'b000});
        end else begin
            r_dac <= DAC_ZERO;
        end
    end

    assign bit_ready = r_bit_ready;
    assign dac_data  = r_dac;

endmodule

// File: tb/tb_bpsk_mod.sv
// Randomized bench for bpsk_mod with a time-based reference model of the
// symbol schedule and carrier phase.
module tb_bpsk_mod;

    logic       clk_32m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       mode    = 1'b0;
    logic [7:0] freq    = 8'd10;
    logic       bit_in  = 1'b0;
    wire        bit_ready;
    wire  [9:0] dac_data;

    bpsk_mod dut (
        .clk_32m   (clk_32m),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .freq      (freq),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .dac_data  (dac_data)
    );

    always #8 clk_32m = ~clk_32m;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int sine_tab [16] = '{512, 708, 873, 984, 1023, 984, 873, 708,
                          512, 316, 151, 40, 1, 40, 151, 316};

    // model state: absolute cycle numbers of load, run start and current symbol
    int m_load_at   = -1;
    bit m_running   = 1'b0;
    int m_run_start = 0;
    int m_sym_start = 0;
    int m_sym_len   = 0;
    bit m_sym_bit   = 1'b0;
    bit m_prev_run  = 1'b0;
    int m_prev_idx  = 0;
    bit m_prev_bit  = 1'b0;
    bit m_prev_br   = 1'b0;

    bit alt      = 1'b0;
    bit alt_val  = 1'b0;
    int last_br  = -1;
    int q_intv[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int len_cycles(input logic [7:0] f);
        case (f)
            8'd10:   return 3200;
            8'd8:    return 4000;
            8'd6:    return 5328;
            default: return 3200;
        endcase
    endfunction

    function automatic int intv_at(input int i);
        if (i < q_intv.size()) return q_intv[i];
        return -1;
    endfunction

    task automatic model_step();
        int exp_dac;
        int exp_br;
        bit cur_run;
        exp_dac = m_prev_run ? sine_tab[(m_prev_idx + ((m_prev_bit && mode) ? 8 : 0)) % 16] : 512;
        exp_br  = 0;
        cur_run = 1'b0;
        if (!rst_n) begin
            m_load_at  = -1;
            m_running  = 1'b0;
            exp_dac    = 512;
        end else if (!en) begin
            m_load_at  = -1;
            m_running  = 1'b0;
        end else if (m_running) begin
            if (m_prev_br) begin
                m_sym_start = cyc;
                m_sym_len   = len_cycles(freq);
                m_sym_bit   = bit_in;
            end
            cur_run = 1'b1;
        end else if (m_load_at >= 0) begin
            m_running   = 1'b1;
            m_run_start = cyc;
            m_sym_start = cyc;
            m_sym_len   = len_cycles(freq);
            m_sym_bit   = bit_in;
            cur_run     = 1'b1;
        end else begin
            m_load_at = cyc;
            exp_br    = 1;
        end
        if (cur_run && (cyc == m_sym_start + m_sym_len - 1)) exp_br = 1;
        m_prev_run = cur_run;
        m_prev_idx = (cyc - m_run_start) % 16;
        m_prev_bit = m_sym_bit;
        m_prev_br  = (exp_br != 0);

        check_eq("dac_data", int'(dac_data), exp_dac);
        check_eq("bit_ready", int'(bit_ready), exp_br);
    endtask

    // Monitor: sample 1 time unit after each rising edge, then drive bit_in.
    initial begin
        forever begin
            @(posedge clk_32m);
            #1;
            cyc = cyc + 1;
            model_step();
            if (!rst_n || !en) begin
                last_br = -1;
            end else if (bit_ready) begin
                if (last_br >= 0) q_intv.push_back(cyc - last_br);
                last_br = cyc;
            end
            if (alt) begin
                if (bit_ready) alt_val = ~alt_val;
                bit_in = alt_val;
            end else begin
                bit_in = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_32m);
    endtask

    initial begin
        wait_cyc(10);
        rst_n = 1'b1;
        wait_cyc(20);

        // 10 kbit/s BPSK, random data
        q_intv.delete();
        freq = 8'd10; mode = 1'b1; en = 1'b1;
        wait_cyc(3 * 3200 + 50);
        en = 1'b0;
        wait_cyc(10);
        check_eq("n_intv_10k", q_intv.size(), 3);
        check_eq("intv_10k", intv_at(2), 3200);

        // ~6 kbit/s, alternating data
        q_intv.delete();
        alt = 1'b1; freq = 8'd6; en = 1'b1;
        wait_cyc(3 * 5328 + 50);
        en = 1'b0;
        wait_cyc(10);
        check_eq("n_intv_6k", q_intv.size(), 3);
        check_eq("intv_6k", intv_at(1), 5328);

        // unmodulated carrier, bits still consumed
        q_intv.delete();
        mode = 1'b0; freq = 8'd10; en = 1'b1;
        wait_cyc(2 * 3200 + 50);
        en = 1'b0;
        wait_cyc(10);
        check_eq("intv_mode0", intv_at(1), 3200);

        // rate change mid-symbol, then an unknown code
        q_intv.delete();
        alt = 1'b0; mode = 1'b1; freq = 8'd10; en = 1'b1;
        wait_cyc(1000);
        freq = 8'd8;
        wait_cyc(3000);
        freq = 8'd99;
        wait_cyc(6500);
        en = 1'b0;
        wait_cyc(10);
        check_eq("intv_chg0", intv_at(0), 3200);
        check_eq("intv_chg1", intv_at(1), 4000);
        check_eq("intv_chg2", intv_at(2), 3200);

        // enable dropped mid-symbol, then restarted
        freq = 8'd10; mode = 1'b1; en = 1'b1;
        wait_cyc(1234);
        en = 1'b0;
        wait_cyc(2);
        check_eq("drop_dac", int'(dac_data), 512);
        en = 1'b1;
        wait_cyc(100);
        en = 1'b0;
        wait_cyc(5);

        // asynchronous reset mid-run
        en = 1'b1;
        wait_cyc(500);
        rst_n = 1'b0;
        #1;
        check_eq("arst_dac", int'(dac_data), 512);
        check_eq("arst_rdy", int'(bit_ready), 0);
        wait_cyc(5);
        en = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(5);
        en = 1'b1;
        wait_cyc(200);
        en = 1'b0;
        wait_cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
